// File: rtl/mem_burst_splitter.sv
// Splits a FIXED/INCR/WRAP burst command into one request per beat on a valid/ready stream.
// Define MEM_BURST_SPLITTER_WRAP_EN to enable WRAP addressing; otherwise WRAP bursts run as INCR.
module mem_burst_splitter #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [AddrWidth-1:0]   cmd_addr_i,
    input  logic [7:0]             cmd_len_i,
    input  logic [2:0]             cmd_size_i,
    input  logic [1:0]             cmd_burst_i,
    input  logic                   cmd_we_i,
    input  logic                   cmd_valid_i,
    output logic                   cmd_ready_o,
    input  logic [DataWidth-1:0]   wdata_i,
    input  logic [DataWidth/8-1:0] wstrb_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    output logic [AddrWidth-1:0]   req_addr_o,
    output logic                   req_we_o,
    output logic [DataWidth-1:0]   req_wdata_o,
    output logic [DataWidth/8-1:0] req_strb_o,
    output logic                   req_last_o,
    output logic                   req_valid_o,
    input  logic                   req_ready_i,
    output logic                   busy_o
);

    localparam int StrbWidth = DataWidth / 8;
    localparam int MaxSize   = $clog2(StrbWidth);

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    state_e               state_q, state_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [7:0]           len_q, len_d;
    logic [2:0]           size_q, size_d;
    logic [1:0]           burst_q, burst_d;
    logic                 we_q, we_d;
    logic [7:0]           beat_q, beat_d;

    logic                 in_burst;
    logic                 req_valid;
    logic                 req_last;
    logic                 req_hs;
    logic                 cmd_ready;
    logic                 cmd_hs;
    logic [2:0]           eff_size;
    logic [AddrWidth-1:0] inc;
    logic [AddrWidth-1:0] incr_addr;
    logic [AddrWidth-1:0] next_addr;

    assign in_burst  = (state_q == BURST);
    assign req_valid = in_burst & (we_q ? wvalid_i : 1'b1);
    assign req_last  = in_burst & (beat_q == len_q);
    assign req_hs    = req_valid & req_ready_i;
    assign cmd_ready = ~in_burst | (req_hs & req_last);
    assign cmd_hs    = cmd_valid_i & cmd_ready;

    assign cmd_ready_o = cmd_ready;
    assign req_valid_o = req_valid;
    assign req_last_o  = req_last;
    assign req_addr_o  = addr_q;
    assign req_we_o    = in_burst & we_q;
    assign wready_o    = in_burst & we_q & req_ready_i;
    assign req_wdata_o = (in_burst & we_q) ? wdata_i : '0;
    assign req_strb_o  = (in_burst & we_q) ? wstrb_i : '0;
    assign busy_o      = in_burst;

    // Beats wider than the data bus are clamped to the bus width.
    assign eff_size  = (cmd_size_i > 3'(MaxSize)) ? 3'(MaxSize) : cmd_size_i;
    assign inc       = AddrWidth'(1) << size_q;
    assign incr_addr = addr_q + inc;

`ifdef MEM_BURST_SPLITTER_WRAP_EN
    logic                 wrap_ok;
    logic [AddrWidth-1:0] wrap_mask;
    logic [AddrWidth-1:0] wrap_addr;

    assign wrap_ok   = (burst_q == 2'b10) &&
                       ((len_q == 8'd1) || (len_q == 8'd3) || (len_q == 8'd7) || (len_q == 8'd15));
    assign wrap_mask = ((AddrWidth'(len_q) + AddrWidth'(1)) << size_q) - AddrWidth'(1);
    assign wrap_addr = (addr_q & ~wrap_mask) | (incr_addr & wrap_mask);

    always_comb begin
        next_addr = incr_addr;
        if (burst_q == 2'b00) begin
            next_addr = addr_q;
        end else if (wrap_ok) begin
            next_addr = wrap_addr;
        end
    end
`else
    always_comb begin
        next_addr = incr_addr;
        if (burst_q == 2'b00) begin
            next_addr = addr_q;
        end
    end
`endif

    // A command accepted alongside the last beat takes priority over returning to IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        we_d    = we_q;
        beat_d  = beat_q;
        if (cmd_hs) begin
            state_d = BURST;
            addr_d  = cmd_addr_i;
            len_d   = cmd_len_i;
            size_d  = eff_size;
            burst_d = cmd_burst_i;
            we_d    = cmd_we_i;
            beat_d  = 8'd0;
        end else if (req_hs) begin
            if (req_last) begin
                state_d = IDLE;
            end else begin
                beat_d = beat_q + 8'd1;
                addr_d = next_addr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            we_q    <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            size_q  <= size_d;
            burst_q <= burst_d;
            we_q    <= we_d;
            beat_q  <= beat_d;
        end
    end

endmodule
